sha256_round_core: RTL and testbench

//  SHA-256 compression engine, directly downstream of the message scheduler.
//  It consumes one Wt word per round over a valid/ready handshake and runs the 64 rounds on working vars a..h.

---
 rtl/sha256_round_core_if.sv | 24 ++
 rtl/sha256_round_core.sv | 114 +++++++++++
 tb/tb_sha256_round_core.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_core_if.sv
// Handshake and result bus between the message scheduler, the compression core and its consumer.
interface sha256_round_core_if #(
    parameter int WORD_W = 32
);
    logic                  start_i;
    logic                  first_i;
    logic [WORD_W-1:0]     wt_i;
    logic                  wt_v_i;
    logic                  wt_ready_o;
    logic [5:0]            round_o;
    logic                  busy_o;
    logic                  digest_v_o;
    logic [8*WORD_W-1:0]   digest_o;

    modport master (
        output start_i, first_i, wt_i, wt_v_i,
        input  wt_ready_o, round_o, busy_o, digest_v_o, digest_o
    );

    modport slave (
        input  start_i, first_i, wt_i, wt_v_i,
        output wt_ready_o, round_o, busy_o, digest_v_o, digest_o
    );
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression core: one schedule word per round over valid/ready,
// folds a..h into the chaining hash after round 63 and holds the digest.
module sha256_round_core #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    sha256_round_core_if.slave bus
);
    localparam int RW = $clog2(ROUNDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [0:7][WORD_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][WORD_W-1:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [1:0]               state_q, state_d;
    logic [RW-1:0]            round_q, round_d;
    logic [0:7][WORD_W-1:0]   v_q, v_d;
    logic [0:7][WORD_W-1:0]   h_q, h_d;
    logic                     hinit_q, hinit_d;
    logic [0:7][WORD_W-1:0]   h_cur;
    logic [WORD_W-1:0]        s0, s1, ch, maj, t1, t2;

    // h_q resets to zero so digest_o reads 0 out of reset; until the first
    // start, the architectural H is still the IV, selected through hinit_q.
    assign h_cur = hinit_q ? h_q : IV;

    always_comb begin
        s1  = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
        ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
        t1  = v_q[7] + s1 + ch + K[round_q] + bus.wt_i;
        s0  = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
        maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
        t2  = s0 + maj;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        v_d     = v_q;
        h_d     = h_q;
        hinit_d = hinit_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    h_d     = bus.first_i ? IV : h_cur;
                    hinit_d = 1'b1;
                    v_d     = h_d;
                    round_d = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (bus.wt_v_i) begin
                    v_d     = {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
                    // Counter wraps to 0 on the last round, ready for the next block.
                    round_d = round_q + 1'b1;
                    if (round_q == RW'(ROUNDS - 1))
                        state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++)
                    h_d[i] = h_q[i] + v_q[i];
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
            v_q     <= '0;
            h_q     <= '0;
            hinit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            v_q     <= v_d;
            h_q     <= h_d;
            hinit_q <= hinit_d;
        end
    end

    assign bus.wt_ready_o = (state_q == S_ROUND);
    assign bus.busy_o     = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign bus.digest_v_o = (state_q == S_DONE);
    assign bus.digest_o   = h_q;
    assign bus.round_o    = round_q;
endmodule

// File: tb/tb_sha256_round_core.sv
// Drives sha256_round_core block by block and compares against a plain SHA-256 model.
module tb_sha256_round_core;
    typedef logic [31:0] w64_t [64];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_round_core_if #(.WORD_W(32)) bus();
    sha256_round_core #(.WORD_W(32), .ROUNDS(64)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc;
    int busy_cnt;
    logic [255:0] hm;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic w64_t sched(input logic [511:0] blk);
        w64_t w;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            a = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            b = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + a + w[i-7] + b;
        end
        return w;
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input w64_t w);
        logic [31:0] hv [8];
        logic [31:0] v [8];
        logic [31:0] x1, x2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255-32*i -: 32];
            v[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits on a negedge; start is presented for the coming edge.
    task automatic run_block(input bit first, input logic [511:0] blk, input int stall_pct,
                             input int pulse_at, input int rst_at, input bit junk);
        w64_t w;
        logic [255:0] exp;
        int t, guard;
        bit v, done;
        w   = sched(blk);
        exp = compress(first ? IV : hm, w);
        bus.start_i = 1'b1;
        bus.first_i = first;
        cyc = 0; busy_cnt = 0; t = 0; guard = 0;
        while (t < 64 && guard < 2000) begin
            @(negedge clk);
            cyc++; guard++;
            if (bus.busy_o) busy_cnt++;
            bus.start_i = (t == pulse_at);
            bus.first_i = 1'b1;
            if (t == rst_at) begin
                rst_n = 1'b0;
                bus.start_i = 1'b0;
                bus.wt_v_i = 1'b0;
                #1;
                check("rst_ready", 256'(bus.wt_ready_o), 256'(0));
                check("rst_busy", 256'(bus.busy_o), 256'(0));
                check("rst_dv", 256'(bus.digest_v_o), 256'(0));
                check("rst_digest", bus.digest_o, 256'(0));
                check("rst_round", 256'(bus.round_o), 256'(0));
                hm = IV;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("ready", 256'(bus.wt_ready_o), 256'(1));
            check("round", 256'(bus.round_o), 256'(t));
            v = ($urandom_range(99, 0) >= stall_pct);
            bus.wt_v_i = v;
            bus.wt_i   = v ? w[t] : $urandom;
            if (v) t++;
        end
        check("feed_timeout", 256'(t), 256'(64));
        done = 1'b0;
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge clk);
            cyc++;
            bus.start_i = 1'b0;
            bus.wt_v_i  = junk;
            bus.wt_i    = $urandom;
            if (bus.busy_o) busy_cnt++;
            if (bus.digest_v_o) done = 1'b1;
            else begin
                check("final_ready", 256'(bus.wt_ready_o), 256'(0));
                check("final_busy", 256'(bus.busy_o), 256'(1));
            end
        end
        check("done_seen", 256'(done), 256'(1));
        check("digest", bus.digest_o, exp);
        check("done_busy", 256'(bus.busy_o), 256'(0));
        check("done_round", 256'(bus.round_o), 256'(0));
        if (stall_pct == 0) begin
            check("lat_dv", 256'(cyc), 256'(66));
            check("lat_busy", 256'(busy_cnt), 256'(65));
        end
        hm = exp;
    endtask

    task automatic idle_junk(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.wt_v_i = 1'b1;
            bus.wt_i   = $urandom;
            check("hold_dv", 256'(bus.digest_v_o), 256'(1));
            check("hold_ready", 256'(bus.wt_ready_o), 256'(0));
        end
        check("hold_digest", bus.digest_o, hm);
        bus.wt_v_i = 1'b0;
    endtask

    initial begin
        logic [511:0] rb;
        bit f;
        bus.start_i = 1'b0; bus.first_i = 1'b0; bus.wt_i = '0; bus.wt_v_i = 1'b0;
        hm = IV;
        @(negedge clk); @(negedge clk);
        check("reset_ready", 256'(bus.wt_ready_o), 256'(0));
        check("reset_busy", 256'(bus.busy_o), 256'(0));
        check("reset_dv", 256'(bus.digest_v_o), 256'(0));
        check("reset_digest", bus.digest_o, 256'(0));
        check("reset_round", 256'(bus.round_o), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // "abc", no stalls, latency measured
        run_block(1'b1, ABC_BLK, 0, -1, -1, 1'b0);
        check("abc_lit", bus.digest_o, ABC_DIG);
        // two-block message started back-to-back on the first DONE cycle
        run_block(1'b1, TWO_B1, 0, -1, -1, 1'b0);
        run_block(1'b0, TWO_B2, 0, -1, -1, 1'b0);
        check("two_lit", bus.digest_o, TWO_DIG);
        // stalls ~50%
        run_block(1'b1, ABC_BLK, 50, -1, -1, 1'b0);
        check("stall_lit", bus.digest_o, ABC_DIG);
        // stray start mid-block, stray wt_v in FINAL/DONE
        run_block(1'b1, ABC_BLK, 0, 20, -1, 1'b1);
        idle_junk(4);
        check("proto_lit", bus.digest_o, ABC_DIG);
        // reset at round 30, then chain from the post-reset IV
        run_block(1'b1, TWO_B1, 0, -1, 30, 1'b0);
        run_block(1'b0, ABC_BLK, 0, -1, -1, 1'b0);
        check("post_rst_lit", bus.digest_o, ABC_DIG);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) rb[511-32*i -: 32] = $urandom;
            f = (n == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            run_block(f, rb, int'($urandom_range(60, 0)), -1, -1, 1'b1);
            if ($urandom_range(1, 0) == 1) idle_junk(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
